rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/hdlc_pkg.sv | 20 ++
 rtl/rx_frame_ctrl_if.sv | 52 +++++
 rtl/rx_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared definitions for the HDLC receive path.
//   rx_ctrl_state_t : state encoding of the Rx frame controller
//   BUF_DEPTH       : default Rx buffer capacity in bytes
//   MIN_FRAME       : default minimum legal frame length in bytes
// -----------------------------------------------------------------------------
package hdlc_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_OPEN    = 2'd1,
        RX_RECEIVE = 2'd2,
        RX_DONE    = 2'd3
    } rx_ctrl_state_t;

    localparam int BUF_DEPTH = 128;
    localparam int MIN_FRAME = 4;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl_if
// Bundle between the Rx datapath/host side and the Rx frame controller.
//   master : drives enable, datapath detect pulses, Rx_Data and host pulses;
//            observes the buffer write port and frame status.
//   slave  : the frame controller (rx_frame_ctrl).
// Signals:
//   RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data[7:0],
//   Rx_ReadDone, Rx_Drop                               (master -> slave)
//   Rx_ValidFrame, Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_AbortSignal,
//   Rx_Overflow, Rx_EoF, Rx_FrameError, Rx_FrameSize, Rx_Ready
//                                                      (slave -> master)
// -----------------------------------------------------------------------------
interface rx_frame_ctrl_if #(
    parameter int BUF_DEPTH = hdlc_pkg::BUF_DEPTH
);
    localparam int AW = $clog2(BUF_DEPTH);

    logic          RxEN;
    logic          Rx_FlagDetect;
    logic          Rx_AbortDetect;
    logic          Rx_NewByte;
    logic [7:0]    Rx_Data;
    logic          Rx_ReadDone;
    logic          Rx_Drop;

    logic          Rx_ValidFrame;
    logic          Rx_WrBuff;
    logic [AW-1:0] Rx_WrAddr;
    logic [7:0]    Rx_WrData;
    logic          Rx_AbortSignal;
    logic          Rx_Overflow;
    logic          Rx_EoF;
    logic          Rx_FrameError;
    logic [AW:0]   Rx_FrameSize;
    logic          Rx_Ready;

    modport master (
        output RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data,
               Rx_ReadDone, Rx_Drop,
        input  Rx_ValidFrame, Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_AbortSignal,
               Rx_Overflow, Rx_EoF, Rx_FrameError, Rx_FrameSize, Rx_Ready
    );

    modport slave (
        input  RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data,
               Rx_ReadDone, Rx_Drop,
        output Rx_ValidFrame, Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_AbortSignal,
               Rx_Overflow, Rx_EoF, Rx_FrameError, Rx_FrameSize, Rx_Ready
    );

endinterface

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// HDLC receive frame controller. Tracks frame boundaries from the datapath
// detect pulses, writes destuffed bytes into the Rx buffer, and reports frame
// completion, abort, overflow and short-frame status to the host.
// Ports:
//   Clk  : system clock, all state changes on its rising edge
//   Rst  : asynchronous active-high reset
//   rxIf : rx_frame_ctrl_if.slave bundle (detect pulses, byte input, host
//          pulses in; buffer write port and frame status out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter int BUF_DEPTH = hdlc_pkg::BUF_DEPTH,
    parameter int MIN_FRAME = hdlc_pkg::MIN_FRAME
) (
    input  logic           Clk,
    input  logic           Rst,
    rx_frame_ctrl_if.slave rxIf
);
    import hdlc_pkg::*;

    localparam int          AW        = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0] MIN_CNT   = (AW+1)'(MIN_FRAME);

    rx_ctrl_state_t state, stateNext;
    logic [AW:0]    count;

    logic           validFrame;
    logic           wrBuff;
    logic [AW-1:0]  wrAddr;
    logic [7:0]     wrData;
    logic           abortSig;
    logic           overflow;
    logic           eof;
    logic           frameError;
    logic [AW:0]    frameSize;
    logic           ready;

    logic           doWrite;
    logic           doOverflow;
    logic           doAbort;
    logic           doEof;
    logic           doClear;

    // Next-state and action decode. Within a state, abort outranks a flag,
    // which outranks a new byte, so a byte arriving with the closing flag is
    // dropped. Losing RxEN returns to IDLE silently, except while a finished
    // frame waits for the host.
    always_comb begin
        stateNext  = state;
        doWrite    = 1'b0;
        doOverflow = 1'b0;
        doAbort    = 1'b0;
        doEof      = 1'b0;
        doClear    = 1'b0;
        if (state != RX_DONE && !rxIf.RxEN) begin
            stateNext = RX_IDLE;
            doClear   = 1'b1;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (rxIf.Rx_FlagDetect) stateNext = RX_OPEN;
                end
                RX_OPEN: begin
                    if (rxIf.Rx_AbortDetect) begin
                        // Abort before any data is not reported to the host.
                        stateNext = RX_IDLE;
                        doClear   = 1'b1;
                    end else if (rxIf.Rx_FlagDetect) begin
                        stateNext = RX_OPEN;
                    end else if (rxIf.Rx_NewByte) begin
                        stateNext = RX_RECEIVE;
                        doWrite   = 1'b1;
                    end
                end
                RX_RECEIVE: begin
                    if (rxIf.Rx_AbortDetect) begin
                        stateNext = RX_IDLE;
                        doAbort   = 1'b1;
                        doClear   = 1'b1;
                    end else if (rxIf.Rx_FlagDetect) begin
                        stateNext = RX_DONE;
                        doEof     = 1'b1;
                    end else if (rxIf.Rx_NewByte) begin
                        // Count saturates at the buffer size; excess bytes
                        // only raise the sticky overflow.
                        if (count < DEPTH_CNT) doWrite    = 1'b1;
                        else                   doOverflow = 1'b1;
                    end
                end
                RX_DONE: begin
                    if (rxIf.Rx_ReadDone || rxIf.Rx_Drop) begin
                        stateNext = RX_IDLE;
                        doClear   = 1'b1;
                    end
                end
                default: begin
                    stateNext = RX_IDLE;
                    doClear   = 1'b1;
                end
            endcase
        end
    end

    // Registered state and outputs; status levels follow the next state so
    // they line up with the state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= RX_IDLE;
            count      <= '0;
            validFrame <= 1'b0;
            wrBuff     <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            abortSig   <= 1'b0;
            overflow   <= 1'b0;
            eof        <= 1'b0;
            frameError <= 1'b0;
            frameSize  <= '0;
            ready      <= 1'b0;
        end else begin
            state      <= stateNext;
            validFrame <= (stateNext == RX_RECEIVE);
            ready      <= (stateNext == RX_DONE);
            wrBuff     <= doWrite;
            abortSig   <= doAbort;
            eof        <= doEof;
            if (doWrite) begin
                wrAddr <= count[AW-1:0];
                wrData <= rxIf.Rx_Data;
                count  <= count + 1'b1;
            end
            if (doOverflow) overflow <= 1'b1;
            if (doEof) begin
                frameSize  <= count;
                frameError <= (count < MIN_CNT);
            end
            if (doClear) begin
                count      <= '0;
                overflow   <= 1'b0;
                frameError <= 1'b0;
                frameSize  <= '0;
            end
        end
    end

    assign rxIf.Rx_ValidFrame  = validFrame;
    assign rxIf.Rx_WrBuff      = wrBuff;
    assign rxIf.Rx_WrAddr      = wrAddr;
    assign rxIf.Rx_WrData      = wrData;
    assign rxIf.Rx_AbortSignal = abortSig;
    assign rxIf.Rx_Overflow    = overflow;
    assign rxIf.Rx_EoF         = eof;
    assign rxIf.Rx_FrameError  = frameError;
    assign rxIf.Rx_FrameSize   = frameSize;
    assign rxIf.Rx_Ready       = ready;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Self-checking bench for rx_frame_ctrl. Expected buffer writes are queued
// when bytes are driven and compared when the DUT strobes Rx_WrBuff; frame
// status is compared directly against bench-computed values.
// -----------------------------------------------------------------------------
module tb_rx_frame_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int vecCnt = 0;
    int errCnt = 0;
    int mCount = 0;
    wr_t expQ[$];

    rx_frame_ctrl_if #(.BUF_DEPTH(DEPTH)) rxIf ();

    rx_frame_ctrl #(.BUF_DEPTH(DEPTH), .MIN_FRAME(4)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .rxIf (rxIf)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulseFlag();
        rxIf.Rx_FlagDetect = 1'b1;
        tick();
        rxIf.Rx_FlagDetect = 1'b0;
    endtask

    task automatic pulseAbort();
        rxIf.Rx_AbortDetect = 1'b1;
        tick();
        rxIf.Rx_AbortDetect = 1'b0;
    endtask

    task automatic openFrame();
        pulseFlag();
        mCount = 0;
    endtask

    // inFrame: the model expects this byte to be stored if room remains.
    task automatic sendByte(input logic [7:0] b, input bit inFrame);
        wr_t w;
        rxIf.Rx_Data    = b;
        rxIf.Rx_NewByte = 1'b1;
        if (inFrame) begin
            if (mCount < DEPTH) begin
                w.addr = AW'(mCount);
                w.data = b;
                expQ.push_back(w);
            end
            if (mCount < DEPTH) mCount++;
        end
        tick();
        rxIf.Rx_NewByte = 1'b0;
    endtask

    task automatic hostRelease(input bit useDrop);
        if (useDrop) rxIf.Rx_Drop = 1'b1;
        else         rxIf.Rx_ReadDone = 1'b1;
        tick();
        rxIf.Rx_Drop     = 1'b0;
        rxIf.Rx_ReadDone = 1'b0;
    endtask

    task automatic checkDrained(input string tag);
        chk(tag, 32'(expQ.size()), 0);
        expQ.delete();
    endtask

    // Write monitor: every strobe must match the next queued write and never
    // coincide with an abort pulse.
    always @(negedge Clk) begin
        if (rxIf.Rx_WrBuff) begin
            chk("wr_with_abort", 32'(rxIf.Rx_AbortSignal), 0);
            if (expQ.size() == 0) begin
                chk("wr_unexpected", 32'(rxIf.Rx_WrAddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("wr_addr", 32'(rxIf.Rx_WrAddr), 32'(e.addr));
                chk("wr_data", 32'(rxIf.Rx_WrData), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rxIf.RxEN           = 1'b0;
        rxIf.Rx_FlagDetect  = 1'b0;
        rxIf.Rx_AbortDetect = 1'b0;
        rxIf.Rx_NewByte     = 1'b0;
        rxIf.Rx_Data        = 8'h00;
        rxIf.Rx_ReadDone    = 1'b0;
        rxIf.Rx_Drop        = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(rxIf.Rx_ValidFrame), 0);
        chk("rst_wrbuff", 32'(rxIf.Rx_WrBuff), 0);
        chk("rst_wraddr", 32'(rxIf.Rx_WrAddr), 0);
        chk("rst_abort", 32'(rxIf.Rx_AbortSignal), 0);
        chk("rst_ovf", 32'(rxIf.Rx_Overflow), 0);
        chk("rst_eof", 32'(rxIf.Rx_EoF), 0);
        chk("rst_ferr", 32'(rxIf.Rx_FrameError), 0);
        chk("rst_fsize", 32'(rxIf.Rx_FrameSize), 0);
        chk("rst_ready", 32'(rxIf.Rx_Ready), 0);
        Rst = 1'b0;

        // Flag with RxEN low is ignored
        pulseFlag();
        sendByte(8'hAA, 1'b0);
        tick();
        rxIf.RxEN = 1'b1;

        // Normal 6-byte frame
        openFrame();
        chk("open_valid", 32'(rxIf.Rx_ValidFrame), 0);
        for (int i = 0; i < 6; i++) sendByte(8'(8'h11 + i), 1'b1);
        chk("rx_valid", 32'(rxIf.Rx_ValidFrame), 1);
        pulseFlag();
        chk("f6_eof", 32'(rxIf.Rx_EoF), 1);
        chk("f6_size", 32'(rxIf.Rx_FrameSize), 6);
        chk("f6_ferr", 32'(rxIf.Rx_FrameError), 0);
        chk("f6_ready", 32'(rxIf.Rx_Ready), 1);
        chk("f6_valid", 32'(rxIf.Rx_ValidFrame), 0);
        // DONE ignores further datapath activity
        sendByte(8'hEE, 1'b0);
        chk("f6_eof_pulse", 32'(rxIf.Rx_EoF), 0);
        pulseAbort();
        chk("done_abort", 32'(rxIf.Rx_AbortSignal), 0);
        chk("done_ready", 32'(rxIf.Rx_Ready), 1);
        tick();
        checkDrained("f6_writes");
        hostRelease(1'b0);
        chk("f6_rel_ready", 32'(rxIf.Rx_Ready), 0);
        chk("f6_rel_size", 32'(rxIf.Rx_FrameSize), 0);

        // Abort after 3 bytes
        openFrame();
        for (int i = 0; i < 3; i++) sendByte(8'(8'h21 + i), 1'b1);
        pulseAbort();
        chk("ab_signal", 32'(rxIf.Rx_AbortSignal), 1);
        chk("ab_ready", 32'(rxIf.Rx_Ready), 0);
        chk("ab_valid", 32'(rxIf.Rx_ValidFrame), 0);
        tick();
        chk("ab_signal_1cyc", 32'(rxIf.Rx_AbortSignal), 0);
        sendByte(8'h99, 1'b0);
        tick();
        checkDrained("ab_writes");

        // Overflow: 130 bytes into a 128-byte buffer
        openFrame();
        for (int i = 0; i < 130; i++) sendByte(8'($urandom_range(0, 255)), 1'b1);
        chk("ov_sticky", 32'(rxIf.Rx_Overflow), 1);
        pulseFlag();
        chk("ov_size", 32'(rxIf.Rx_FrameSize), 128);
        chk("ov_flag", 32'(rxIf.Rx_Overflow), 1);
        chk("ov_ready", 32'(rxIf.Rx_Ready), 1);
        tick();
        checkDrained("ov_writes");
        hostRelease(1'b1);
        chk("ov_cleared", 32'(rxIf.Rx_Overflow), 0);
        chk("ov_rel_ready", 32'(rxIf.Rx_Ready), 0);

        // Short frame
        openFrame();
        sendByte(8'h31, 1'b1);
        sendByte(8'h32, 1'b1);
        pulseFlag();
        chk("sh_ferr", 32'(rxIf.Rx_FrameError), 1);
        chk("sh_size", 32'(rxIf.Rx_FrameSize), 2);
        tick();
        checkDrained("sh_writes");
        hostRelease(1'b0);
        chk("sh_ferr_clr", 32'(rxIf.Rx_FrameError), 0);
        chk("sh_size_clr", 32'(rxIf.Rx_FrameSize), 0);
        chk("sh_ready_clr", 32'(rxIf.Rx_Ready), 0);

        // Back-to-back flags, then a frame exactly MIN_FRAME long
        openFrame();
        pulseFlag();
        for (int i = 0; i < 4; i++) sendByte(8'(8'h41 + i), 1'b1);
        pulseFlag();
        chk("mn_ferr", 32'(rxIf.Rx_FrameError), 0);
        chk("mn_size", 32'(rxIf.Rx_FrameSize), 4);
        tick();
        checkDrained("mn_writes");
        hostRelease(1'b1);

        // Reset mid-frame, then a clean 5-byte frame
        openFrame();
        for (int i = 0; i < 4; i++) sendByte(8'(8'h61 + i), 1'b1);
        tick();
        checkDrained("rs_pre_writes");
        #2;
        Rst = 1'b1;
        #1;
        chk("rs_async_valid", 32'(rxIf.Rx_ValidFrame), 0);
        tick();
        Rst = 1'b0;
        openFrame();
        for (int i = 0; i < 5; i++) sendByte(8'(8'h51 + i), 1'b1);
        pulseFlag();
        chk("rs_size", 32'(rxIf.Rx_FrameSize), 5);
        chk("rs_ferr", 32'(rxIf.Rx_FrameError), 0);
        tick();
        checkDrained("rs_writes");
        hostRelease(1'b0);

        // Flag and abort together: abort wins, no end-of-frame
        openFrame();
        for (int i = 0; i < 3; i++) sendByte(8'(8'h71 + i), 1'b1);
        rxIf.Rx_FlagDetect  = 1'b1;
        rxIf.Rx_AbortDetect = 1'b1;
        tick();
        rxIf.Rx_FlagDetect  = 1'b0;
        rxIf.Rx_AbortDetect = 1'b0;
        chk("fa_abort", 32'(rxIf.Rx_AbortSignal), 1);
        chk("fa_eof", 32'(rxIf.Rx_EoF), 0);
        tick();
        chk("fa_eof_late", 32'(rxIf.Rx_EoF), 0);
        chk("fa_ready", 32'(rxIf.Rx_Ready), 0);
        checkDrained("fa_writes");

        // RxEN dropped mid-frame: silent return to idle
        openFrame();
        sendByte(8'h81, 1'b1);
        sendByte(8'h82, 1'b1);
        rxIf.RxEN = 1'b0;
        tick();
        chk("en_valid", 32'(rxIf.Rx_ValidFrame), 0);
        chk("en_abort", 32'(rxIf.Rx_AbortSignal), 0);
        chk("en_eof", 32'(rxIf.Rx_EoF), 0);
        rxIf.RxEN = 1'b1;
        tick();
        checkDrained("en_writes");

        // Byte coinciding with closing flag is discarded
        openFrame();
        for (int i = 0; i < 4; i++) sendByte(8'(8'h91 + i), 1'b1);
        rxIf.Rx_FlagDetect = 1'b1;
        rxIf.Rx_NewByte    = 1'b1;
        rxIf.Rx_Data       = 8'hFF;
        tick();
        rxIf.Rx_FlagDetect = 1'b0;
        rxIf.Rx_NewByte    = 1'b0;
        chk("fb_size", 32'(rxIf.Rx_FrameSize), 4);
        chk("fb_eof", 32'(rxIf.Rx_EoF), 1);
        tick();
        checkDrained("fb_writes");
        hostRelease(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
